// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 state encoding, command constants and parity helper
//
// Purpose: common definitions for the PS/2 host transmitter (and the receive path).
// Ports:   none (package).
// Build option: none here; PS2_TX_GLITCH_FILTER_EN is consumed by ps2_line_sync.

package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_BITS      = 3'd3,
        ST_ACK       = 3'd4,
        ST_WAIT_IDLE = 3'd5,
        ST_DONE      = 3'd6
    } ps2_tx_state_e;

    localparam logic [7:0] PS2_CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] PS2_ACK          = 8'hFA;

    // Bit index of the stop bit within the 10-bit host frame {stop, parity, data}.
    localparam logic [3:0] PS2_STOP_IDX = 4'd9;

    // PS/2 uses odd parity: total ones across data+parity is odd.
    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// rtl/ps2_line_sync.sv - 2-FF synchronizer, optional glitch filter and fall detector for one PS/2 line
//
// Purpose: bring a raw open-drain PS/2 pin into the clk domain and flag 1->0 transitions.
// Ports:
//   clk    in  system clock
//   reset  in  synchronous, active-high
//   din    in  raw asynchronous pin level
//   level  out synchronized (and, if enabled, filtered) line level
//   fall   out one-cycle pulse when level goes 1->0
// Build option: PS2_TX_GLITCH_FILTER_EN -- level changes only after FILTER_LEN consecutive
//   equal synchronized samples; otherwise level follows the synchronizer directly.

module ps2_line_sync #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic level,
    output logic fall
);

`ifdef PS2_TX_GLITCH_FILTER_EN
    localparam bit FILTER_EN = 1'b1;
`else
    localparam bit FILTER_EN = 1'b0;
`endif

    // With the filter disabled a run length of one makes level track the synchronizer.
    localparam int EFF_LEN = FILTER_EN ? FILTER_LEN : 1;
    localparam int RUN_W   = $clog2(EFF_LEN + 1);

    logic             meta_q, sync_q;
    logic             level_q, level_d;
    logic             prev_q;
    logic [RUN_W-1:0] run_q, run_d;

    // Count consecutive samples that disagree with the current level; any agreeing sample
    // restarts the run, so short glitches never reach the output.
    always_comb begin
        level_d = level_q;
        run_d   = '0;
        if (sync_q != level_q) begin
            if (run_q == RUN_W'(EFF_LEN - 1)) begin
                level_d = sync_q;
            end else begin
                run_d = run_q + RUN_W'(1);
            end
        end
    end

    // Idle PS/2 lines are pulled high, so reset to 1 to avoid a false fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q  <= 1'b1;
            sync_q  <= 1'b1;
            level_q <= 1'b1;
            prev_q  <= 1'b1;
            run_q   <= '0;
        end else begin
            meta_q  <= din;
            sync_q  <= meta_q;
            level_q <= level_d;
            prev_q  <= level_q;
            run_q   <= run_d;
        end
    end

    assign level = level_q;
    assign fall  = prev_q & ~level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device byte transmitter driving open-drain pull-low enables
//
// Purpose: send one command byte to a PS/2 device (inhibit, request-to-send, 10 bits, ack).
// Ports:
//   clk100       in   100 MHz system clock
//   reset        in   synchronous, active-high
//   ps2_clk_in   in   raw PS/2 clock pin level
//   ps2_data_in  in   raw PS/2 data pin level
//   ps2_clk_oe   out  1 = pull PS/2 clock low
//   ps2_data_oe  out  1 = pull PS/2 data low
//   tx_data      in   byte to send, sampled with tx_start
//   tx_start     in   one-cycle request, ignored unless idle
//   tx_busy      out  frame in progress
//   tx_complete  out  one-cycle end-of-frame pulse
//   tx_error     out  one-cycle pulse with tx_complete on NACK or timeout
// Build option: PS2_TX_GLITCH_FILTER_EN (see ps2_line_sync).

module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int INHIBIT_CYCLES = 10000,
    parameter int TIMEOUT_CYCLES = 2000000,
    parameter int FILTER_LEN     = 8
) (
    input  logic       clk100,
    input  logic       reset,
    input  logic       ps2_clk_in,
    input  logic       ps2_data_in,
    output logic       ps2_clk_oe,
    output logic       ps2_data_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       tx_busy,
    output logic       tx_complete,
    output logic       tx_error
);

    localparam int CNT_MAX = (TIMEOUT_CYCLES > INHIBIT_CYCLES) ? TIMEOUT_CYCLES : INHIBIT_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] INHIBIT_LAST = CNT_W'(INHIBIT_CYCLES - 1);
    // Start bit goes low one cycle before the clock is released so data is stable first.
    localparam logic [CNT_W-1:0] START_AT     = CNT_W'(INHIBIT_CYCLES - 2);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    ps2_tx_state_e    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bit_q, bit_d;
    logic [9:0]       frame_q, frame_d;
    logic             clk_oe_q, clk_oe_d;
    logic             data_oe_q, data_oe_d;
    logic             err_q, err_d;

    logic clk_level, clk_fall;
    logic data_level, data_fall_unused;
    logic timing;

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_clk_sync (
        .clk   (clk100),
        .reset (reset),
        .din   (ps2_clk_in),
        .level (clk_level),
        .fall  (clk_fall)
    );

    ps2_line_sync #(.FILTER_LEN(FILTER_LEN)) u_data_sync (
        .clk   (clk100),
        .reset (reset),
        .din   (ps2_data_in),
        .level (data_level),
        .fall  (data_fall_unused)
    );

    // States in which the device owns the clock and may stall us forever.
    assign timing = (state_q == ST_REQ) || (state_q == ST_BITS) ||
                    (state_q == ST_ACK) || (state_q == ST_WAIT_IDLE);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_d     = bit_q;
        frame_d   = frame_q;
        clk_oe_d  = clk_oe_q;
        data_oe_d = data_oe_q;
        err_d     = err_q;

        case (state_q)
            ST_IDLE: begin
                if (tx_start) begin
                    frame_d   = {1'b1, odd_parity(tx_data), tx_data};
                    bit_d     = '0;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    clk_oe_d  = 1'b1;
                    data_oe_d = 1'b0;
                    state_d   = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == START_AT) begin
                    data_oe_d = 1'b1;
                end
                if (cnt_q == INHIBIT_LAST) begin
                    clk_oe_d  = 1'b0;
                    data_oe_d = 1'b1;
                    cnt_d     = '0;
                    state_d   = ST_REQ;
                end
            end
            ST_REQ: begin
                state_d = ST_BITS;
            end
            ST_BITS: begin
                // Update data only right after a fall, while the device holds clock low.
                if (clk_fall) begin
                    data_oe_d = ~frame_q[bit_q];
                    if (bit_q == PS2_STOP_IDX) begin
                        state_d = ST_ACK;
                    end else begin
                        bit_d = bit_q + 4'd1;
                    end
                end
            end
            ST_ACK: begin
                if (clk_fall) begin
                    err_d   = data_level;
                    state_d = ST_WAIT_IDLE;
                end
            end
            ST_WAIT_IDLE: begin
                if (clk_level && data_level) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Counter was cleared on REQ entry; it lands DONE exactly TIMEOUT_CYCLES later.
        if (timing) begin
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == TIMEOUT_LAST) begin
                state_d   = ST_DONE;
                err_d     = 1'b1;
                clk_oe_d  = 1'b0;
                data_oe_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk100) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            bit_q     <= '0;
            frame_q   <= '0;
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_q     <= bit_d;
            frame_q   <= frame_d;
            clk_oe_q  <= clk_oe_d;
            data_oe_q <= data_oe_d;
            err_q     <= err_d;
        end
    end

    assign ps2_clk_oe  = clk_oe_q;
    assign ps2_data_oe = data_oe_q;
    assign tx_busy     = (state_q != ST_IDLE);
    assign tx_complete = (state_q == ST_DONE);
    assign tx_error    = (state_q == ST_DONE) & err_q;

endmodule
